// File: rtl/wptr_full.sv
// Write-side pointer and full/almost-full/level logic for an async FIFO.
// Binary pointer drives memory addressing; its Gray copy crosses to the reader.
module wptr_full #(
    parameter int ADDR_SIZE    = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic                 sclk,
    input  logic                 srst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 wovf
);

    localparam int PW = ADDR_SIZE + 1;
    // Full when the write Gray pointer equals the read one with its top two bits inverted
    localparam logic [PW-1:0] FMASK  = PW'(3) << (ADDR_SIZE - 1);
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          accept;

    assign accept     = winc & ~wfull;
    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign level_next = wbin_next - rbin;
    assign wen        = accept;
    assign waddr      = wbin[ADDR_SIZE-1:0];

    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == (wq2_rptr ^ FMASK));
            walmost_full <= (level_next >= THRESH);
            wlevel       <= level_next;
            wovf         <= wovf | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with ADDR_SIZE=2, AFULL_THRESH=3.
// Inputs change on the falling edge; registered outputs are sampled 1ns after the rising edge.
module tb_wptr_full;

    logic       sclk;
    logic       srst;
    logic       winc;
    logic [2:0] wq2_rptr;
    logic       wen;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [2:0] wlevel;
    logic       wovf;

    int checks = 0;
    int errors = 0;

    wptr_full #(.ADDR_SIZE(2), .AFULL_THRESH(3)) dut (
        .sclk(sclk),
        .srst(srst),
        .winc(winc),
        .wq2_rptr(wq2_rptr),
        .wen(wen),
        .waddr(waddr),
        .wptr(wptr),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .wlevel(wlevel),
        .wovf(wovf)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_tick();
        @(posedge sclk);
        #1;
    endtask

    logic [2:0] gseq [0:9];
    logic [2:0] prev;

    initial begin
        gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011;
        gseq[3] = 3'b010; gseq[4] = 3'b110; gseq[5] = 3'b111;
        gseq[6] = 3'b101; gseq[7] = 3'b100; gseq[8] = 3'b000;
        gseq[9] = 3'b001;

        srst = 1'b1;
        winc = 1'b0;
        wq2_rptr = 3'b000;
        repeat (2) @(negedge sclk);
        srst = 1'b0;

        // two pushes, then asynchronous reset between edges
        winc = 1'b1;
        edge_tick();
        edge_tick();
        chk("pre_rst_wptr", wptr, 3'b011);
        chk("pre_rst_wlevel", wlevel, 3'd2);
        winc = 1'b0;
        #1;
        srst = 1'b1;
        #1;
        chk("rst_wptr", wptr, 3'b000);
        chk("rst_wfull", wfull, 1'b0);
        chk("rst_afull", walmost_full, 1'b0);
        chk("rst_wlevel", wlevel, 3'd0);
        chk("rst_wovf", wovf, 1'b0);
        chk("rst_waddr", waddr, 2'd0);
        chk("rst_wen", wen, 1'b0);

        // first push after reset writes address 0
        @(negedge sclk);
        srst = 1'b0;
        winc = 1'b1;
        #1;
        chk("post_rst_wen", wen, 1'b1);
        chk("post_rst_waddr", waddr, 2'd0);
        edge_tick();
        chk("post_rst_wptr", wptr, 3'b001);
        @(negedge sclk);
        winc = 1'b0;
        srst = 1'b1;
        @(negedge sclk);
        srst = 1'b0;

        // fill with reader idle
        wq2_rptr = 3'b000;
        winc = 1'b1;
        #1;
        chk("fill_waddr0", waddr, 2'd0);
        edge_tick();
        chk("fill_wptr1", wptr, 3'b001);
        chk("fill_waddr1", waddr, 2'd1);
        chk("fill_afull1", walmost_full, 1'b0);
        chk("fill_wlevel1", wlevel, 3'd1);
        edge_tick();
        chk("fill_wptr2", wptr, 3'b011);
        chk("fill_waddr2", waddr, 2'd2);
        chk("fill_afull2", walmost_full, 1'b0);
        edge_tick();
        chk("fill_wptr3", wptr, 3'b010);
        chk("fill_waddr3", waddr, 2'd3);
        chk("fill_afull3", walmost_full, 1'b1);
        chk("fill_full3", wfull, 1'b0);
        edge_tick();
        chk("fill_wptr4", wptr, 3'b110);
        chk("fill_full4", wfull, 1'b1);
        chk("fill_wlevel4", wlevel, 3'd4);
        chk("fill_wen_full", wen, 1'b0);
        chk("fill_wovf4", wovf, 1'b0);
        edge_tick();
        chk("ovf_wptr", wptr, 3'b110);
        chk("ovf_wovf", wovf, 1'b1);
        chk("ovf_full", wfull, 1'b1);

        // reader advances by one
        @(negedge sclk);
        winc = 1'b0;
        wq2_rptr = 3'b001;
        edge_tick();
        chk("drain_full", wfull, 1'b0);
        chk("drain_wlevel", wlevel, 3'd3);
        chk("drain_afull", walmost_full, 1'b1);
        chk("drain_wovf", wovf, 1'b1);

        // back to full, then push coinciding with reader advance
        @(negedge sclk);
        wq2_rptr = 3'b000;
        edge_tick();
        chk("refull_full", wfull, 1'b1);
        @(negedge sclk);
        winc = 1'b1;
        wq2_rptr = 3'b001;
        edge_tick();
        chk("coinc_wptr", wptr, 3'b110);
        chk("coinc_full", wfull, 1'b0);
        edge_tick();
        chk("coinc2_wptr", wptr, 3'b111);
        chk("coinc2_full", wfull, 1'b1);
        chk("coinc2_wlevel", wlevel, 3'd4);

        // reader tracking two edges behind
        @(negedge sclk);
        winc = 1'b0;
        srst = 1'b1;
        @(negedge sclk);
        srst = 1'b0;
        winc = 1'b1;
        prev = 3'b000;
        for (int k = 0; k < 9; k++) begin
            wq2_rptr = (k >= 2) ? gseq[k-2] : 3'b000;
            #1;
            chk($sformatf("trk_waddr%0d", k), waddr, 32'(k % 4));
            edge_tick();
            chk($sformatf("trk_wptr%0d", k), wptr, gseq[k+1]);
            chk($sformatf("trk_full%0d", k), wfull, 1'b0);
            chk($sformatf("trk_onebit%0d", k), $countones(wptr ^ prev), 1);
            prev = wptr;
            @(negedge sclk);
        end
        winc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
